// File: rtl/cmlink_dcp_decoder.sv
// Camera Link receive decoder: maps 1-3 chip words to fval/lval/dval and ports A..I,
// and adds frame/line events, pixel/line counters, line-length measurement and sticky errors.
module cmlink_dcp_decoder #(
  parameter int CHIPS       = 1,
  parameter int SPLIT_PHASE = 0,
  parameter int DVAL_EN     = 1,
  parameter int XW          = 14,
  parameter int YW          = 14
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [28*CHIPS-1:0]   i_cm_data,
  input  logic                  i_err_clr,
  output logic                  o_fvld,
  output logic                  o_lvld,
  output logic                  o_dvld,
  output logic [24*CHIPS-1:0]   o_port,
  output logic                  o_sof,
  output logic                  o_eof,
  output logic                  o_sol,
  output logic                  o_eol,
  output logic [XW-1:0]         o_pix_cnt,
  output logic [YW-1:0]         o_line_cnt,
  output logic [XW-1:0]         o_line_len,
  output logic [3:0]            o_err
);

  // Bits driven while the serial clock is high: 20-23, 25-27.
  localparam logic [27:0] HI_MASK = 28'hEF0_0000;
  localparam int DW = 28 * CHIPS;
  localparam int PW = 24 * CHIPS;

  logic [DW-1:0]    dly_q, eff;
  logic [PW-1:0]    port_d, port_q;
  logic [CHIPS-1:0] chip_f, chip_l, chip_d;

  logic fval_d, lval_d, dval_d, fval_q, lval_q, dval_q;
  logic sof_d, eof_d, sol_d, eol_d, sof_q, eof_q, sol_q, eol_q;
  logic seen_low_d, seen_low_q, in_frame_d, in_frame_q, have_prev_d, have_prev_q;
  logic pv_q, sat, len_err, chip_err;
  logic [XW-1:0] pix_next, pix_d, pix_q, len_d, len_q;
  logic [YW-1:0] line_d, line_q;
  logic [3:0]    err_d, err_q;

  always_comb begin
    eff = i_cm_data;
    if (SPLIT_PHASE != 0) begin
      eff = ({CHIPS{HI_MASK}} & i_cm_data) | (~{CHIPS{HI_MASK}} & dly_q);
    end
  end

  for (genvar c = 0; c < CHIPS; c++) begin : g_chip
    logic [27:0] w;
    logic        unused_spare;
    assign w = eff[28*c +: 28];
    assign port_d[24*c +: 24] = {w[20], w[16], w[13], w[9],  w[5],  w[1],  w[26], w[22],
                                 w[12], w[8],  w[18], w[14], w[10], w[6],  w[2],  w[27],
                                 w[4],  w[0],  w[23], w[19], w[15], w[11], w[7],  w[3]};
    assign chip_f[c] = w[21];
    assign chip_l[c] = w[17];
    assign chip_d[c] = w[25];
    assign unused_spare = w[24];
  end

  // Only chip X dval matters; the delay register is idle when SPLIT_PHASE is 0.
  logic unused_ok;
  assign unused_ok = ^{dly_q, chip_d};

  always_comb begin
    fval_d   = chip_f[0];
    lval_d   = chip_l[0];
    dval_d   = chip_d[0];
    chip_err = (chip_f != {CHIPS{chip_f[0]}}) | (chip_l != {CHIPS{chip_l[0]}});

    // A frame only starts after fval has been seen low, so a mid-frame reset release stays idle.
    sof_d      = fval_d & ~fval_q & seen_low_q;
    eof_d      = ~fval_d & fval_q & in_frame_q;
    sol_d      = lval_d & ~lval_q & fval_d & (in_frame_q | sof_d);
    eol_d      = ~lval_d & lval_q & fval_q & in_frame_q;
    seen_low_d = seen_low_q | ~fval_d;
    in_frame_d = in_frame_q;
    if (sof_d)      in_frame_d = 1'b1;
    else if (eof_d) in_frame_d = 1'b0;

    pv_q     = fval_q & lval_q & (dval_q | (DVAL_EN == 0)) & in_frame_q;
    sat      = pv_q & (&pix_q);
    pix_next = (pv_q & ~(&pix_q)) ? pix_q + XW'(1) : pix_q;
    pix_d    = sol_d ? '0 : pix_next;
    len_d    = eol_d ? pix_next : len_q;
    len_err  = eol_d & have_prev_q & (pix_next != len_q);

    line_d      = line_q;
    have_prev_d = have_prev_q;
    if (sof_d) begin
      line_d      = '0;
      have_prev_d = 1'b0;
    end else if (eol_d) begin
      line_d      = line_q + YW'(1);
      have_prev_d = 1'b1;
    end

    err_d = (i_err_clr ? 4'b0 : err_q) | {sat, chip_err, len_err, lval_d & ~fval_d};
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      dly_q       <= '0;
      port_q      <= '0;
      fval_q      <= 1'b0;
      lval_q      <= 1'b0;
      dval_q      <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      sol_q       <= 1'b0;
      eol_q       <= 1'b0;
      seen_low_q  <= 1'b0;
      in_frame_q  <= 1'b0;
      have_prev_q <= 1'b0;
      pix_q       <= '0;
      len_q       <= '0;
      line_q      <= '0;
      err_q       <= '0;
    end else begin
      dly_q       <= i_cm_data;
      port_q      <= port_d;
      fval_q      <= fval_d;
      lval_q      <= lval_d;
      dval_q      <= dval_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      sol_q       <= sol_d;
      eol_q       <= eol_d;
      seen_low_q  <= seen_low_d;
      in_frame_q  <= in_frame_d;
      have_prev_q <= have_prev_d;
      pix_q       <= pix_d;
      len_q       <= len_d;
      line_q      <= line_d;
      err_q       <= err_d;
    end
  end

  assign o_fvld     = fval_q;
  assign o_lvld     = lval_q;
  assign o_dvld     = dval_q;
  assign o_port     = port_q;
  assign o_sof      = sof_q;
  assign o_eof      = eof_q;
  assign o_sol      = sol_q;
  assign o_eol      = eol_q;
  assign o_pix_cnt  = pix_q;
  assign o_line_cnt = line_q;
  assign o_line_len = len_q;
  assign o_err      = err_q;

endmodule

// File: doc/cmlink_dcp_decoder.md
Name: cmlink_dcp_decoder

Overview:
- Parametrised Camera Link receive decoder. Takes 1-3 deserialised 28-bit chip words (X/Y/Z) and produces registered fval/lval/dval and 8-bit ports A..I.
- Adds what the single-chip decoder lacks:
  - selectable clock-phase alignment
  - pixel/line counters
  - frame/line event pulses
  - line-length measurement
  - sticky protocol-error flags
- Sits between the selectio deserialiser and the video input FIFO.

Parameters:
- CHIPS, 1, number of chips: 1=base (A-C), 2=medium (A-F), 3=full (A-I).
- SPLIT_PHASE, 0, 0 = all bits taken from the current word; 1 = clk-high-slot bits (23,27,20,26,22,21,25) from the current word, all others from the previous word.
- DVAL_EN, 1, 1 = pixel counting qualified by dval; 0 = dval treated as 1.
- XW, 14, pixel counter / line length width.
- YW, 14, line counter width.

Ports:
- i_clk  in  1  pixel clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_cm_data  in  28*CHIPS  chip words; chip X in [27:0], Y in [55:28], Z in [83:56].
- i_err_clr  in  1  synchronous clear of o_err.
- o_fvld  out  1  frame valid (chip X).
- o_lvld  out  1  line valid (chip X).
- o_dvld  out  1  data valid (chip X).
- o_port  out  24*CHIPS  ports {..,C,B,A} per chip; A in [7:0].
- o_sof  out  1  one-cycle pulse on fval rise.
- o_eof  out  1  one-cycle pulse on fval fall.
- o_sol  out  1  one-cycle pulse on lval rise while fval=1.
- o_eol  out  1  one-cycle pulse on lval fall while fval=1.
- o_pix_cnt  out  XW  index of current valid pixel within the line.
- o_line_cnt  out  YW  index of current line within the frame.
- o_line_len  out  XW  valid-pixel count of the last completed line.
- o_err  out  4  sticky errors: [0] lval high while fval low; [1] line length differs from previous line in the same frame; [2] chip fval/lval mismatch; [3] pixel counter saturated.

Behaviour:
- Bit map, per chip word w:
  - A = {w4,w0,w23,w19,w15,w11,w7,w3}
  - B = {w12,w8,w18,w14,w10,w6,w2,w27}
  - C = {w20,w16,w13,w9,w5,w1,w26,w22}
  - fval = w21, lval = w17, dval = w25
- Latency: one register stage. Outputs at edge n+1 reflect i_cm_data sampled at edge n. In SPLIT_PHASE=1, the non-clk-high bits come from the word sampled at edge n-1 via an internal 28*CHIPS delay register; the first word after reset uses 0 for those bits.
- Chips Y/Z: only the port bits reach the outputs. Their fval/lval are compared against chip X for err[2].
- Events: computed on the decoded (registered) fval/lval versus their previous registered value. Pulses are aligned with the first/last cycle of the new level, i.e. o_sof is high in the same cycle o_fvld first reads 1.
- Pixel valid (pv) = fval & lval & (dval | !DVAL_EN).
- o_pix_cnt:
  - reset to 0 on o_sol;
  - increments after each pv cycle;
  - saturates at 2^XW-1 and sets err[3].
- o_line_len: loaded on o_eol with the count of pv cycles in that line.
- o_line_cnt:
  - 0 on o_sof;
  - increments on each o_eol;
  - wraps at 2^YW.
- err[1]: set at o_eol if the line length differs from the previous line's length in the same frame. Not checked for the first line of a frame.
- err[0]: set on any cycle with lval=1 and fval=0.
- err[2]: set on any cycle where enabled chips disagree on fval or lval.
- Simultaneous fval and lval rise: o_sof and o_sol both pulse; o_line_cnt=0, o_pix_cnt=0.
- Simultaneous fval and lval fall: o_eol and o_eof both pulse; o_line_len updated, then o_line_cnt held until the next o_sof.
- i_err_clr clears o_err. A new error in the same cycle wins (bit stays set).
- Reset, including mid-frame: all outputs, counters, delay register and previous-level registers go to 0, and no pulses are generated. After reset, the decoder waits for an fval rise before counting lines; an lval rise with fval=0 only flags err[0].

Test Plan:
- CHIPS=1, SPLIT_PHASE=0: word with only bits 3, 22, 27 set -> next cycle o_port=24'h010101 and fvld/lvld/dvld all 0.
- SPLIT_PHASE=1: word1=28'h0000008 then word2=28'h0000000 -> o_port[7:0]=0 after word1, 8'h01 after word2. Also: word with bit 23 set -> A5=1 in the same latency as fval.
- Frame of 3 lines x 16 pixels with dval=1: o_sof once, three o_sol/o_eol pairs, o_line_len=16, final o_line_cnt=3, o_eof once, o_err=0.
- Second line 15 pixels, DVAL_EN=1, dval low for 4 cycles of a 20-cycle line -> err[1] set at that line's o_eol; the dval line gives o_line_len=16. Then i_err_clr -> o_err=0.
- CHIPS=3: chip Y lval held low while X lval high -> err[2]=1. Separately, lval pulse with fval=0 -> err[0]=1 and no o_sol.
- i_rstn asserted mid-line at pixel 7 -> all outputs 0 immediately. After release, a mid-frame lval produces no o_sof, and o_line_cnt stays 0 until the next fval rise.
